mbs_fsk_tx_ctrl: RTL and testbench

MBS_FSK_TX_CTRL -- requirements
Module: mbs_fsk_tx_ctrl

---
 rtl/mbs_fsk_tx_ctrl.sv | 218 +++++++++++++++++++++
 tb/tb_mbs_fsk_tx_ctrl.sv | 348 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mbs_fsk_tx_ctrl.sv
// -----------------------------------------------------------------------------
// mbs_fsk_tx_ctrl
//
// Frame sequencer for an FSK transmitter. Each accepted byte is sent as a
// frame:
//   [preamble 1,0,1,... (pre_len bits)] [start 0] [8 data bits, LSB first]
//   [stop 1]
// Every bit lasts baud_div+1 clocks. For each bit the matching NCO tuning
// word is driven: the mark word for a 1 and the space word for a 0. When a
// new byte is accepted in the last clock of STOP, the next frame begins
// directly with START, with no preamble and no idle gap.
//
// Handshake: a byte is transferred on a rising edge where
// tx_valid && tx_ready. tx_ready is combinational and does not depend on
// tx_valid, so the source can hold tx_valid high and the two sides can never
// deadlock. Data and all cfg_* values are latched on that same edge and stay
// fixed for the whole frame.
//
// Ports
//   wb_clk_i        clock, rising edge
//   wb_rst_i        asynchronous active-high reset
//   enable          permits new frames to be accepted
//   cfg_mark_word   tuning word for a logic-1 bit       (PHASE_W)
//   cfg_space_word  tuning word for a logic-0 bit       (PHASE_W)
//   cfg_baud_div    bit period minus one, in clocks     (DIV_W)
//   cfg_pre_len     number of preamble bits, 0-15
//   tx_valid        the source has a byte
//   tx_data         byte to send
//   tx_ready        the controller accepts the byte this cycle (combinational)
//   nco_word        tuning word driven to the NCO       (registered)
//   nco_en          NCO run enable                      (registered)
//   bit_out         bit currently being keyed           (registered)
//   busy            a frame is in progress              (registered)
//   frame_cnt       completed-frame count, wraps        (registered)
//   dbg_state       current FSM state, for observation
// -----------------------------------------------------------------------------
module mbs_fsk_tx_ctrl #(
   parameter int PHASE_W = 24,
   parameter int DIV_W   = 16
) (
   input  logic               wb_clk_i,
   input  logic               wb_rst_i,
   input  logic               enable,
   input  logic [PHASE_W-1:0] cfg_mark_word,
   input  logic [PHASE_W-1:0] cfg_space_word,
   input  logic [DIV_W-1:0]   cfg_baud_div,
   input  logic [3:0]         cfg_pre_len,
   input  logic               tx_valid,
   input  logic [7:0]         tx_data,
   output logic               tx_ready,
   output logic [PHASE_W-1:0] nco_word,
   output logic               nco_en,
   output logic               bit_out,
   output logic               busy,
   output logic [15:0]        frame_cnt,
   output logic [2:0]         dbg_state
);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      PRE   = 3'd1,
      START = 3'd2,
      DATA  = 3'd3,
      STOP  = 3'd4
   } state_t;

   state_t             state;
   logic [DIV_W-1:0]   div_cnt;   // clocks left in the current bit, minus one
   logic [3:0]         bit_cnt;   // bit index inside PRE or DATA
   logic [7:0]         data_q;
   logic [PHASE_W-1:0] mark_q;
   logic [PHASE_W-1:0] space_q;
   logic [DIV_W-1:0]   baud_q;
   logic [3:0]         pre_q;

   logic               bit_end;   // last clock of the current bit
   logic               accept;
   logic [2:0]         nxt_idx;
   logic               nxt_data_bit;
   logic [3:0]         pre_last;

   assign bit_end      = (div_cnt == '0);
   assign nxt_idx      = bit_cnt[2:0] + 3'd1;
   assign nxt_data_bit = data_q[nxt_idx];
   assign pre_last     = pre_q - 4'd1;
   assign dbg_state    = state;

   // Ready in IDLE, or in the final clock of STOP so back-to-back frames
   // follow without a gap.
   always_comb begin
      tx_ready = 1'b0;
      if (state == IDLE)
         tx_ready = enable;
      else if (state == STOP && bit_end)
         tx_ready = enable;
   end

   assign accept = tx_valid && tx_ready;

   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         state     <= IDLE;
         div_cnt   <= '0;
         bit_cnt   <= '0;
         data_q    <= '0;
         mark_q    <= '0;
         space_q   <= '0;
         baud_q    <= '0;
         pre_q     <= '0;
         bit_out   <= 1'b1;
         nco_word  <= '0;
         nco_en    <= 1'b0;
         busy      <= 1'b0;
         frame_cnt <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  data_q  <= tx_data;
                  mark_q  <= cfg_mark_word;
                  space_q <= cfg_space_word;
                  baud_q  <= cfg_baud_div;
                  pre_q   <= cfg_pre_len;
                  div_cnt <= cfg_baud_div;
                  bit_cnt <= '0;
                  nco_en  <= 1'b1;
                  busy    <= 1'b1;
                  if (cfg_pre_len != 4'd0) begin
                     state    <= PRE;
                     bit_out  <= 1'b1;
                     nco_word <= cfg_mark_word;
                  end else begin
                     state    <= START;
                     bit_out  <= 1'b0;
                     nco_word <= cfg_space_word;
                  end
               end
            end

            PRE, START, DATA, STOP: begin
               if (!bit_end) begin
                  div_cnt <= div_cnt - 1'b1;
               end else begin
                  // Bit boundary: reload the divider and pick the next bit.
                  div_cnt <= baud_q;
                  case (state)
                     PRE: begin
                        if (bit_cnt == pre_last) begin
                           state    <= START;
                           bit_out  <= 1'b0;
                           nco_word <= space_q;
                        end else begin
                           // Preamble alternates, so the next bit is the
                           // complement of the current one.
                           bit_cnt  <= bit_cnt + 4'd1;
                           bit_out  <= ~bit_out;
                           nco_word <= bit_out ? space_q : mark_q;
                        end
                     end

                     START: begin
                        state    <= DATA;
                        bit_cnt  <= '0;
                        bit_out  <= data_q[0];
                        nco_word <= data_q[0] ? mark_q : space_q;
                     end

                     DATA: begin
                        if (bit_cnt == 4'd7) begin
                           state    <= STOP;
                           bit_out  <= 1'b1;
                           nco_word <= mark_q;
                        end else begin
                           bit_cnt  <= bit_cnt + 4'd1;
                           bit_out  <= nxt_data_bit;
                           nco_word <= nxt_data_bit ? mark_q : space_q;
                        end
                     end

                     default: begin  // STOP
                        frame_cnt <= frame_cnt + 16'd1;
                        if (accept) begin
                           // Back-to-back frame: straight to START.
                           data_q   <= tx_data;
                           mark_q   <= cfg_mark_word;
                           space_q  <= cfg_space_word;
                           baud_q   <= cfg_baud_div;
                           pre_q    <= cfg_pre_len;
                           div_cnt  <= cfg_baud_div;
                           bit_cnt  <= '0;
                           state    <= START;
                           bit_out  <= 1'b0;
                           nco_word <= cfg_space_word;
                        end else begin
                           state    <= IDLE;
                           bit_cnt  <= '0;
                           div_cnt  <= '0;
                           bit_out  <= 1'b1;
                           nco_word <= mark_q;
                           nco_en   <= 1'b0;
                           busy     <= 1'b0;
                        end
                     end
                  endcase
               end
            end

            default: begin
               state   <= IDLE;
               bit_out <= 1'b1;
               nco_en  <= 1'b0;
               busy    <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mbs_fsk_tx_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mbs_fsk_tx_ctrl
//
// Reference model: every accepted frame is expanded into a queue with one
// entry per clock (bit value and tuning word). The head of the queue is what
// the outputs must show this cycle; an empty queue means idle. tx_ready is
// expected when the queue is empty or holds only its final entry. Inputs
// change 1 time unit after the rising edge; outputs are compared on the
// falling edge.
// -----------------------------------------------------------------------------
module tb_mbs_fsk_tx_ctrl;

   localparam int PW = 24;
   localparam int DW = 16;

   // ---------------- clock / reset ----------------
   logic          clk = 1'b0;
   logic          rst = 1'b1;
   always #5 clk = ~clk;

   logic          enable = 1'b1;
   logic [PW-1:0] cfg_mark_word = '0;
   logic [PW-1:0] cfg_space_word = '0;
   logic [DW-1:0] cfg_baud_div = '0;
   logic [3:0]    cfg_pre_len = '0;
   logic          tx_valid = 1'b0;
   logic [7:0]    tx_data = '0;
   logic          tx_ready;
   logic [PW-1:0] nco_word;
   logic          nco_en;
   logic          bit_out;
   logic          busy;
   logic [15:0]   frame_cnt;
   logic [2:0]    dbg_state;

   mbs_fsk_tx_ctrl #(.PHASE_W(PW), .DIV_W(DW)) dut (
      .wb_clk_i      (clk),
      .wb_rst_i      (rst),
      .enable        (enable),
      .cfg_mark_word (cfg_mark_word),
      .cfg_space_word(cfg_space_word),
      .cfg_baud_div  (cfg_baud_div),
      .cfg_pre_len   (cfg_pre_len),
      .tx_valid      (tx_valid),
      .tx_data       (tx_data),
      .tx_ready      (tx_ready),
      .nco_word      (nco_word),
      .nco_en        (nco_en),
      .bit_out       (bit_out),
      .busy          (busy),
      .frame_cnt     (frame_cnt),
      .dbg_state     (dbg_state)
   );

   int checks = 0;
   int failures = 0;
   int cyc = 0;
   always @(posedge clk) cyc++;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s t=%0t actual=%0h required=%0h", nm, $time, act, exp);
      end
   endtask

   // ---------------- reference model ----------------
   typedef struct packed {
      logic          b;
      logic [PW-1:0] w;
   } cyc_t;

   cyc_t          m_q[$];
   logic [PW-1:0] m_last_mark = '0;
   logic [15:0]   m_cnt = '0;
   int            m_acc_cnt = 0;
   int            m_was;
   logic          m_acc;

   task automatic push_frame(input logic [7:0] d, input logic [3:0] pre,
                             input logic [DW-1:0] div, input logic [PW-1:0] mk,
                             input logic [PW-1:0] sp);
      logic b_q[$];
      for (int i = 0; i < int'(pre); i++) b_q.push_back((i % 2) == 0);
      b_q.push_back(1'b0);
      for (int i = 0; i < 8; i++) b_q.push_back(d[i]);
      b_q.push_back(1'b1);
      foreach (b_q[k])
         for (int r = 0; r <= int'(div); r++)
            m_q.push_back({b_q[k], b_q[k] ? mk : sp});
   endtask

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_q.delete();
         m_last_mark = '0;
         m_cnt = '0;
      end else begin
         m_was = m_q.size();
         m_acc = tx_valid && enable && (m_was <= 1);
         if (m_was > 0) begin
            void'(m_q.pop_front());
            if (m_was == 1) m_cnt++;
         end
         if (m_acc) begin
            push_frame(tx_data, (m_was == 0) ? cfg_pre_len : 4'd0, cfg_baud_div,
                       cfg_mark_word, cfg_space_word);
            m_last_mark = cfg_mark_word;
            m_acc_cnt++;
         end
      end
   end

   // ---------------- compare process + capture ----------------
   logic          cap_b[$];
   logic [PW-1:0] cap_w[$];
   int            cap_t[$];
   logic          e_busy, e_bit, e_rdy;
   logic [PW-1:0] e_w;

   always @(negedge clk) begin
      e_busy = (m_q.size() > 0);
      if (e_busy) begin
         e_bit = m_q[0].b;
         e_w   = m_q[0].w;
         e_rdy = enable && (m_q.size() == 1);
      end else begin
         e_bit = 1'b1;
         e_w   = m_last_mark;
         e_rdy = enable;
      end
      chk("tx_ready", tx_ready, e_rdy);
      chk("bit_out", bit_out, e_bit);
      chk("nco_word", nco_word, e_w);
      chk("nco_en", nco_en, e_busy);
      chk("busy", busy, e_busy);
      chk("frame_cnt", frame_cnt, m_cnt);
      if (busy) begin
         cap_b.push_back(bit_out);
         cap_w.push_back(nco_word);
         cap_t.push_back(cyc);
      end
   end

   // ---------------- driver tasks ----------------
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      @(posedge clk);
      #3 rst = 1'b1;
      @(posedge clk);
      #3 rst = 1'b0;
      step();
   endtask

   task automatic wait_acc(input int start);
      int n = 0;
      while (m_acc_cnt == start && n < 400) begin
         step();
         n++;
      end
      chk("accept_seen", m_acc_cnt != start, 1);
   endtask

   task automatic wait_idle();
      int n = 0;
      while (m_q.size() != 0 && n < 2000) begin
         step();
         n++;
      end
      chk("idle_reached", busy, 0);
   endtask

   task automatic clear_cap();
      cap_b.delete();
      cap_w.delete();
      cap_t.delete();
   endtask

   task automatic send_one(input logic [7:0] d);
      int s;
      s = m_acc_cnt;
      tx_data  = d;
      tx_valid = 1'b1;
      wait_acc(s);
      tx_valid = 1'b0;
      wait_idle();
   endtask

   // ---------------- watchdog ----------------
   initial begin
      #3000000;
      $display("FAIL watchdog t=%0t", $time);
      $fatal(1, "watchdog expired");
   end

   // ---------------- stimulus ----------------
   logic [9:0]  pat1;
   logic [13:0] pat2;
   logic [21:0] pat3;

   initial begin
      #23 rst = 1'b0;
      step();

      // Reset values
      chk("rst_bit_out", bit_out, 1);
      chk("rst_nco_word", nco_word, 0);
      chk("rst_busy", busy, 0);
      chk("rst_frame_cnt", frame_cnt, 0);

      // 0xA5, baud_div=3, no preamble
      pat1 = 10'b1101001010;
      cfg_baud_div = 16'd3; cfg_pre_len = 4'd0;
      cfg_mark_word = 24'h111111; cfg_space_word = 24'h222222;
      clear_cap();
      send_one(8'hA5);
      chk("t1_busy_cycles", cap_b.size(), 40);
      for (int i = 0; i < 40 && i < cap_b.size(); i++)
         chk("t1_bit", cap_b[i], pat1[i/4]);
      chk("t1_frame_cnt", frame_cnt, 1);

      // preamble 4, baud_div=0, mark/space words
      pat2 = 14'b10011110000101;
      cfg_baud_div = 16'd0; cfg_pre_len = 4'd4;
      cfg_mark_word = 24'h123456; cfg_space_word = 24'h0ABCDE;
      clear_cap();
      send_one(8'h3C);
      chk("t2_busy_cycles", cap_b.size(), 14);
      for (int i = 0; i < 14 && i < cap_b.size(); i++) begin
         chk("t2_bit", cap_b[i], pat2[i]);
         chk("t2_word", cap_w[i], pat2[i] ? 24'h123456 : 24'h0ABCDE);
      end
      chk("t2_frame_cnt", frame_cnt, 2);

      // back-to-back 0x00 then 0xFF, tx_valid held
      begin
         int s;
         pat3 = 22'b1111111110100000000001;
         cfg_pre_len = 4'd2;
         clear_cap();
         s = m_acc_cnt;
         tx_data = 8'h00; tx_valid = 1'b1;
         wait_acc(s);
         tx_data = 8'hFF;
         wait_acc(s + 1);
         tx_valid = 1'b0;
         wait_idle();
         chk("t3_busy_cycles", cap_b.size(), 22);
         if (cap_t.size() == 22) chk("t3_no_gap", cap_t[21] - cap_t[0], 21);
         for (int i = 0; i < 22 && i < cap_b.size(); i++)
            chk("t3_bit", cap_b[i], pat3[i]);
         chk("t3_frame_cnt", frame_cnt, 4);
      end

      // enable dropped during DATA bit 3
      begin
         int s;
         cfg_baud_div = 16'd1; cfg_pre_len = 4'd0;
         clear_cap();
         s = m_acc_cnt;
         tx_data = 8'h5A; tx_valid = 1'b1;
         wait_acc(s);
         repeat (8) step();
         enable = 1'b0;
         wait_idle();
         chk("t4_busy_cycles", cap_b.size(), 20);
         for (int i = 0; i < 5; i++) begin
            chk("t4_tx_ready", tx_ready, 0);
            chk("t4_busy", busy, 0);
            step();
         end
         chk("t4_no_accept", m_acc_cnt, s + 1);
         chk("t4_frame_cnt", frame_cnt, 5);
         tx_valid = 1'b0;
         enable = 1'b1;
      end

      // reset pulse mid-DATA
      begin
         int s;
         do_reset();
         cfg_baud_div = 16'd2; cfg_pre_len = 4'd1;
         s = m_acc_cnt;
         tx_data = 8'hC3; tx_valid = 1'b1;
         wait_acc(s);
         tx_valid = 1'b0;
         repeat (10) step();
         #2 rst = 1'b1;
         #1;
         chk("t5_bit_out", bit_out, 1);
         chk("t5_nco_en", nco_en, 0);
         chk("t5_busy", busy, 0);
         chk("t5_nco_word", nco_word, 0);
         chk("t5_frame_cnt", frame_cnt, 0);
         @(posedge clk);
         #3 rst = 1'b0;
         repeat (40) step();
         chk("t5_frame_cnt_after", frame_cnt, 0);
      end

      // frame_cnt wrap from a preset value
      begin
         int s;
         force dut.frame_cnt = 16'hFFFD;
         m_cnt = 16'hFFFD;
         #1 release dut.frame_cnt;
         step();
         chk("t6_preset", frame_cnt, 16'hFFFD);
         cfg_baud_div = 16'd0; cfg_pre_len = 4'd0;
         s = m_acc_cnt;
         tx_data = 8'h81; tx_valid = 1'b1;
         wait_acc(s);
         wait_acc(s + 1);
         wait_acc(s + 2);
         tx_valid = 1'b0;
         wait_idle();
         chk("t6_wrap", frame_cnt, 16'h0000);
      end

      // randomized traffic with mid-frame cfg churn and rare resets
      for (int i = 0; i < 3000; i++) begin
         enable         = ($urandom_range(0, 9) != 0);
         tx_valid       = $urandom_range(0, 1);
         tx_data        = 8'($urandom);
         cfg_mark_word  = 24'($urandom);
         cfg_space_word = 24'($urandom);
         cfg_baud_div   = 16'($urandom_range(0, 3));
         cfg_pre_len    = 4'($urandom_range(0, 15));
         if ($urandom_range(0, 499) == 0) begin
            #2 rst = 1'b1;
            #4 rst = 1'b0;
         end
         step();
      end
      tx_valid = 1'b0;
      enable = 1'b1;
      wait_idle();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
